// File: rtl/lcd_buf_pkg.sv
// Shared widths, clear-FSM states and requester indices for the display
// buffer arbiter.
package lcd_buf_pkg;

  localparam int unsigned LCD_AW = 13;
  localparam int unsigned LCD_DW = 8;

  typedef enum logic [1:0] {
    C_IDLE = 2'd0,
    C_RUN  = 2'd1,
    C_DONE = 2'd2
  } clr_state_e;

  // Bit positions in the one-hot grant vector
  localparam logic [1:0] REQ_CAP  = 2'd0;
  localparam logic [1:0] REQ_HOST = 2'd1;
  localparam logic [1:0] REQ_TFT  = 2'd2;
  localparam logic [1:0] REQ_CLR  = 2'd3;

  typedef enum logic [1:0] {
    RD_NONE = 2'd0,
    RD_TFT  = 2'd1,
    RD_HOST = 2'd2
  } rd_sel_e;

endpackage

// File: rtl/lcd_buf_arb_if.sv
// Requester, clear-control and RAM-side signals of the display buffer arbiter.
interface lcd_buf_arb_if
  import lcd_buf_pkg::*;
#(
  parameter int unsigned AW = LCD_AW,
  parameter int unsigned DW = LCD_DW
);
  logic          cap_req;
  logic [AW-1:0] cap_addr;
  logic [DW-1:0] cap_wdata;
  logic          cap_ack;

  logic          tft_rdreq;
  logic [AW-1:0] tft_raddr;
  logic          tft_rdack;
  logic [DW-1:0] tft_rdata;

  logic          host_req;
  logic          host_we;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_wdata;
  logic          host_ack;
  logic [DW-1:0] host_rdata;
  logic          host_rvalid;

  logic          clr_start;
  logic [DW-1:0] clr_data;
  logic          clr_busy;
  logic          clr_done;

  logic          ram_cs;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;

  modport slave (
    input  cap_req, cap_addr, cap_wdata,
    output cap_ack,
    input  tft_rdreq, tft_raddr,
    output tft_rdack, tft_rdata,
    input  host_req, host_we, host_addr, host_wdata,
    output host_ack, host_rdata, host_rvalid,
    input  clr_start, clr_data,
    output clr_busy, clr_done,
    output ram_cs, ram_we, ram_addr, ram_wdata,
    input  ram_rdata
  );

  modport master (
    output cap_req, cap_addr, cap_wdata,
    input  cap_ack,
    output tft_rdreq, tft_raddr,
    input  tft_rdack, tft_rdata,
    output host_req, host_we, host_addr, host_wdata,
    input  host_ack, host_rdata, host_rvalid,
    output clr_start, clr_data,
    input  clr_busy, clr_done,
    input  ram_cs, ram_we, ram_addr, ram_wdata,
    output ram_rdata
  );

endinterface

// File: rtl/lcd_buf_clr.sv
// Buffer-clear engine: walks 0..CLR_LAST, one write per granted cycle,
// and pulses clr_done once at the end.
module lcd_buf_clr
  import lcd_buf_pkg::*;
#(
  parameter int unsigned   AW       = LCD_AW,
  parameter logic [AW-1:0] CLR_LAST = 'h17bf
) (
  input  logic          clk,
  input  logic          rst_x,
  input  logic          clr_start,
  input  logic          clr_gnt,
  output logic          clr_req,
  output logic [AW-1:0] clr_addr,
  output logic          clr_busy,
  output logic          clr_done
);

  clr_state_e    state_r, state_nx;
  logic [AW-1:0] clr_cnt_r, clr_cnt_nx;

  always_ff @(posedge clk or negedge rst_x) begin
    if (!rst_x) begin
      state_r   <= C_IDLE;
      clr_cnt_r <= '0;
    end else begin
      state_r   <= state_nx;
      clr_cnt_r <= clr_cnt_nx;
    end
  end

  // The counter only moves on a granted write, so a preempted clear
  // resumes at the same address.
  always_comb begin
    state_nx   = state_r;
    clr_cnt_nx = clr_cnt_r;
    unique case (state_r)
      C_IDLE: begin
        if (clr_start) begin
          clr_cnt_nx = '0;
          state_nx   = C_RUN;
        end
      end
      C_RUN: begin
        if (clr_gnt) begin
          if (clr_cnt_r == CLR_LAST) state_nx = C_DONE;
          else                       clr_cnt_nx = clr_cnt_r + AW'(1);
        end
      end
      C_DONE:  state_nx = C_IDLE;
      default: state_nx = C_IDLE;
    endcase
  end

  assign clr_req  = (state_r == C_RUN);
  assign clr_busy = (state_r == C_RUN) || (state_r == C_DONE);
  assign clr_done = (state_r == C_DONE);
  assign clr_addr = clr_cnt_r;

endmodule

// File: rtl/lcd_buf_arb.sv
// Single-port display buffer arbiter: cap > starved host > tft > host > clear,
// one combinational grant per cycle, read data returned one cycle later.
module lcd_buf_arb
  import lcd_buf_pkg::*;
#(
  parameter int unsigned   AW       = LCD_AW,
  parameter int unsigned   DW       = LCD_DW,
  parameter int unsigned   HOST_MAX = 7,
  parameter logic [AW-1:0] CLR_LAST = 'h17bf
) (
  input logic           clk,
  input logic           rst_x,
  lcd_buf_arb_if.slave  bus
);

  logic [3:0]    gnt;
  logic [2:0]    host_wait_r;
  logic          host_urgent;
  rd_sel_e       rd_sel_r, rd_sel_nx;
  logic          clr_req;
  logic [AW-1:0] clr_addr;

  lcd_buf_clr #(
    .AW       (AW),
    .CLR_LAST (CLR_LAST)
  ) u_clr (
    .clk       (clk),
    .rst_x     (rst_x),
    .clr_start (bus.clr_start),
    .clr_gnt   (gnt[REQ_CLR]),
    .clr_req   (clr_req),
    .clr_addr  (clr_addr),
    .clr_busy  (bus.clr_busy),
    .clr_done  (bus.clr_done)
  );

  assign host_urgent = bus.host_req && (host_wait_r == 3'(HOST_MAX));

  always_comb begin
    gnt = '0;
    if      (bus.cap_req)   gnt[REQ_CAP]  = 1'b1;
    else if (host_urgent)   gnt[REQ_HOST] = 1'b1;
    else if (bus.tft_rdreq) gnt[REQ_TFT]  = 1'b1;
    else if (bus.host_req)  gnt[REQ_HOST] = 1'b1;
    else if (clr_req)       gnt[REQ_CLR]  = 1'b1;
  end

  assign bus.cap_ack   = gnt[REQ_CAP];
  assign bus.host_ack  = gnt[REQ_HOST];
  assign bus.tft_rdack = gnt[REQ_TFT];

  always_ff @(posedge clk or negedge rst_x) begin
    if (!rst_x) begin
      host_wait_r <= '0;
    end else if (bus.host_req && !gnt[REQ_HOST]) begin
      if (!host_urgent) host_wait_r <= host_wait_r + 3'd1;
    end else begin
      host_wait_r <= '0;
    end
  end

  always_comb begin
    bus.ram_we    = 1'b0;
    bus.ram_addr  = '0;
    bus.ram_wdata = '0;
    if (gnt[REQ_CAP]) begin
      bus.ram_we    = 1'b1;
      bus.ram_addr  = bus.cap_addr;
      bus.ram_wdata = bus.cap_wdata;
    end else if (gnt[REQ_HOST]) begin
      bus.ram_we    = bus.host_we;
      bus.ram_addr  = bus.host_addr;
      bus.ram_wdata = bus.host_wdata;
    end else if (gnt[REQ_TFT]) begin
      bus.ram_addr  = bus.tft_raddr;
    end else if (gnt[REQ_CLR]) begin
      bus.ram_we    = 1'b1;
      bus.ram_addr  = clr_addr;
      bus.ram_wdata = bus.clr_data;
    end
  end

  assign bus.ram_cs = |gnt;

  always_comb begin
    rd_sel_nx = RD_NONE;
    if (gnt[REQ_TFT])                       rd_sel_nx = RD_TFT;
    else if (gnt[REQ_HOST] && !bus.host_we) rd_sel_nx = RD_HOST;
  end

  always_ff @(posedge clk or negedge rst_x) begin
    if (!rst_x) rd_sel_r <= RD_NONE;
    else        rd_sel_r <= rd_sel_nx;
  end

  assign bus.tft_rdata   = bus.ram_rdata;
  assign bus.host_rdata  = bus.ram_rdata;
  assign bus.host_rvalid = (rd_sel_r == RD_HOST);

endmodule
